dpram_access_ctrl: RTL and testbench
====================================

Name: dpram_access_ctrl

Overview:
- Initiator-side controller for the 16x8 synchronous dual-port RAM (sync_dualram_16X8).
- Accepts write/read commands on a valid/ready command channel and drives the RAM write and read ports.
- Captures registered RAM read data and returns it, with its address, on a valid/ready response channel.
- Used in place of hand-driven task stimulus when RAM traffic must be flow-controlled.

Parameters:
- ADDR_WIDTH, 4, RAM address width.
- DEPTH, 16, RAM locations; equals 2**ADDR_WIDTH.
- DATA_WIDTH, 8, RAM data width.
- RSP_DEPTH, 4, response FIFO entries; power of 2, at least 2.
- INIT_VAL, 8'h00, value written to every location by the init sweep.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_we  in  1  1 = write, 0 = read; held stable while cmd_valid is high.
- cmd_addr  in  ADDR_WIDTH  command address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  read response present.
- rsp_ready  in  1  response consumed when high together with rsp_valid.
- rsp_data  out  DATA_WIDTH  read data.
- rsp_addr  out  ADDR_WIDTH  address the data was read from.
- wr_enb  out  1  RAM write enable.
- wr_addr  out  ADDR_WIDTH  RAM write address.
- wr_data  out  DATA_WIDTH  RAM write data.
- rd_enb  out  1  RAM read enable.
- rd_addr  out  ADDR_WIDTH  RAM read address.
- rd_data  in  DATA_WIDTH  RAM registered read data, valid 1 clk after rd_enb is sampled.
- init_done  out  1  high once the controller is in RUN.

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs 0, response FIFO empty, in-flight count 0.
  - FSM goes to INIT if DPRAM_CTRL_INIT_EN is defined, else RUN.
  - Reset asserted mid-operation discards in-flight reads and buffered responses; no rsp_valid pulse follows.
- FSM states:
  - INIT: init counter steps 0..DEPTH-1, one location per clk. wr_enb=1, wr_addr=counter, wr_data=INIT_VAL. cmd_ready=0, rd_enb=0.
  - INIT exits to RUN after the write to DEPTH-1. Takes exactly DEPTH clks; no wrap.
  - RUN: init_done=1. State is held until reset.
- Command acceptance in RUN:
  - cmd_ready = cmd_we OR (inflight + fifo_count < RSP_DEPTH). cmd_ready may depend on cmd_we.
- Write accepted at edge k: wr_enb=1 with wr_addr/wr_data from the command during cycle k..k+1. RAM stores at edge k+1.
- Read accepted at edge k:
  - rd_enb=1 with rd_addr during cycle k..k+1; inflight increments.
  - At edge k+2, rd_data and the delayed address are pushed into the FIFO; inflight decrements.
  - rsp_valid is high from edge k+2. Accept-to-response latency is 2 clks when the FIFO is empty.
- wr_enb and rd_enb are registered. They are 0 in any cycle following an edge with no accepted command of that type.
- One command per clk, so wr_enb and rd_enb are never both high in RUN.
- Back-to-back reads sustain 1 read/clk while rsp_ready=1; RSP_DEPTH=4 covers the 2-clk latency.
- Response FIFO:
  - FIFO is first-word-fall-through; responses return in command order.
  - Push and pop on the same edge keep the count unchanged.
  - Push never overflows; credit gating guarantees space.
  - rsp_data/rsp_addr hold while rsp_valid=1 and rsp_ready=0.
- Read-after-write to the same address on consecutive accepts returns the new data: the write lands at edge k+1, the read is sampled at edge k+2.

Optional Feature:
- DPRAM_CTRL_INIT_EN defined: after every reset the INIT sweep writes INIT_VAL to all DEPTH locations. init_done rises DEPTH clks after reset release.
- DPRAM_CTRL_INIT_EN undefined: no INIT state. The controller is in RUN immediately after reset, init_done=1 from the first edge, and RAM contents are left untouched.

Test Plan:
- INIT_EN defined, reset release -> wr_enb high 16 clks, addresses 0..15, data 8'h00, then init_done=1 and cmd_ready=1. A read of addr 4'h7 returns 8'h00.
- Write 8'hA5 to 4'h3, then read 4'h3 on the next clk -> rsp_valid 2 clks after the read accept, rsp_data=8'hA5, rsp_addr=4'h3.
- Write 16 locations (addr n, data n+8'h10), then 16 back-to-back reads with rsp_ready=1 -> 1 response/clk, in order, data n+8'h10, no cmd_ready drop.
- Reads with rsp_ready=0 -> exactly 4 reads accepted, then cmd_ready=0 for reads while writes are still accepted. Raising rsp_ready drains 4 in-order responses and reads resume.
- rst pulsed low with 2 reads in flight and 1 response buffered -> all outputs 0 immediately, no stale rsp_valid after release, INIT sweep restarts.

Source files
------------

// File: rtl/dpram_access_ctrl.sv
// dpram_access_ctrl: initiator-side controller for a synchronous dual-port RAM
// (one write port, one registered read port). It takes write/read commands on a
// valid/ready command channel, drives the RAM ports, and returns read data with
// its address through a first-word-fall-through response FIFO.
//
// Optional feature: define DPRAM_CTRL_INIT_EN to sweep INIT_VAL into every RAM
// location after each reset before commands are accepted. When it is undefined
// the controller enters RUN straight out of reset and leaves RAM contents alone.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  command accepted when high with cmd_valid (combinational, depends on cmd_we)
//   cmd_we     1 = write, 0 = read
//   cmd_addr   command address
//   cmd_wdata  write data (ignored for reads)
//   rsp_valid  read response present
//   rsp_ready  response consumed when high with rsp_valid
//   rsp_data   read data
//   rsp_addr   address the data was read from
//   wr_enb     RAM write enable
//   wr_addr    RAM write address
//   wr_data    RAM write data
//   rd_enb     RAM read enable
//   rd_addr    RAM read address
//   rd_data    RAM registered read data, valid 1 clk after rd_enb is sampled
//   init_done  high once the controller is in RUN
module dpram_access_ctrl #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RSP_DEPTH  = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  wr_enb,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_enb,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  init_done
);

  localparam int unsigned PTR_W = $clog2(RSP_DEPTH);
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

`ifdef DPRAM_CTRL_INIT_EN
  localparam state_t RST_STATE = ST_INIT;
`else
  localparam state_t RST_STATE = ST_RUN;
`endif

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_init_cnt, w_init_cnt_nxt;

  logic                  r_wr_enb, w_wr_enb_nxt;
  logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wr_data, w_wr_data_nxt;
  logic                  r_rd_enb, w_rd_enb_nxt;
  logic [ADDR_WIDTH-1:0] r_rd_addr, w_rd_addr_nxt;
  logic                  r_init_done, w_init_done_nxt;

  // Read pipeline: rd_enb delayed once lines up with the RAM's registered data.
  logic                  r_rd_vld_d;
  logic [ADDR_WIDTH-1:0] r_rd_addr_d;
  logic [CNT_W-1:0]      r_inflight;

  logic [DATA_WIDTH-1:0] r_fifo_data [RSP_DEPTH];
  logic [ADDR_WIDTH-1:0] r_fifo_addr [RSP_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]      r_fifo_cnt, w_fifo_cnt_nxt;
  logic                  r_rsp_valid;

  logic                  w_credit, w_cmd_ready, w_acc_wr, w_acc_rd;
  logic                  w_push, w_pop;

  // Reads need a FIFO slot reserved for every read not yet consumed; writes never do.
  assign w_credit    = (SUM_W'(r_inflight) + SUM_W'(r_fifo_cnt)) < SUM_W'(RSP_DEPTH);
  // r_init_done is low in reset and during INIT, which keeps cmd_ready low there.
  assign w_cmd_ready = r_init_done & (cmd_we | w_credit);
  assign w_acc_wr    = cmd_valid & w_cmd_ready &  cmd_we;
  assign w_acc_rd    = cmd_valid & w_cmd_ready & ~cmd_we;

  assign w_push         = r_rd_vld_d;
  assign w_pop          = r_rsp_valid & rsp_ready;
  assign w_fifo_cnt_nxt = r_fifo_cnt + CNT_W'(w_push) - CNT_W'(w_pop);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= RST_STATE;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  // Next state and next values of the registered RAM-side outputs.
  always_comb begin
    w_state_nxt     = r_state;
    w_init_cnt_nxt  = r_init_cnt;
    w_wr_enb_nxt    = 1'b0;
    w_wr_addr_nxt   = r_wr_addr;
    w_wr_data_nxt   = r_wr_data;
    w_rd_enb_nxt    = 1'b0;
    w_rd_addr_nxt   = r_rd_addr;
    w_init_done_nxt = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_wr_enb_nxt   = 1'b1;
        w_wr_addr_nxt  = r_init_cnt;
        w_wr_data_nxt  = INIT_VAL;
        w_init_cnt_nxt = r_init_cnt + ADDR_WIDTH'(1);
        if (r_init_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
          w_state_nxt     = ST_RUN;
          w_init_done_nxt = 1'b1;
          w_init_cnt_nxt  = '0;
        end
      end
      ST_RUN: begin
        w_init_done_nxt = 1'b1;
        if (w_acc_wr) begin
          w_wr_enb_nxt  = 1'b1;
          w_wr_addr_nxt = cmd_addr;
          w_wr_data_nxt = cmd_wdata;
        end
        if (w_acc_rd) begin
          w_rd_enb_nxt  = 1'b1;
          w_rd_addr_nxt = cmd_addr;
        end
      end
      default: w_state_nxt = RST_STATE;
    endcase
  end

  // Registered RAM-side outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_enb    <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_rd_enb    <= 1'b0;
      r_rd_addr   <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_wr_enb    <= w_wr_enb_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_rd_enb    <= w_rd_enb_nxt;
      r_rd_addr   <= w_rd_addr_nxt;
      r_init_done <= w_init_done_nxt;
    end
  end

  // Read tracking and response FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_vld_d  <= 1'b0;
      r_rd_addr_d <= '0;
      r_inflight  <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fifo_cnt  <= '0;
      r_rsp_valid <= 1'b0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_addr[i] <= '0;
      end
    end else begin
      r_rd_vld_d  <= r_rd_enb;
      r_rd_addr_d <= r_rd_addr;
      r_inflight  <= r_inflight + CNT_W'(w_acc_rd) - CNT_W'(w_push);
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= rd_data;
        r_fifo_addr[r_wr_ptr] <= r_rd_addr_d;
        r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_fifo_cnt  <= w_fifo_cnt_nxt;
      r_rsp_valid <= (w_fifo_cnt_nxt != '0);
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_fifo_data[r_rd_ptr];
  assign rsp_addr  = r_fifo_addr[r_rd_ptr];
  assign wr_enb    = r_wr_enb;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign rd_enb    = r_rd_enb;
  assign rd_addr   = r_rd_addr;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_dpram_access_ctrl.sv
// Testbench for dpram_access_ctrl: a behavioural RAM plus a transaction-level
// reference model (expected memory image and an ordered queue of outstanding reads).
`timescale 1ns/1ps
module tb_dpram_access_ctrl;

  localparam int unsigned AW     = 4;
  localparam int unsigned DW     = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned RSPD   = 4;
  localparam logic [7:0]  INIT_V = 8'h00;
`ifdef DPRAM_CTRL_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif
  localparam int RUN_CYC = INIT_EN ? DEPTH : 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rsp_addr;
  logic          wr_enb, rd_enb, init_done;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, rd_data;

  always #5 clk = ~clk;

  dpram_access_ctrl #(
    .ADDR_WIDTH(AW), .DEPTH(DEPTH), .DATA_WIDTH(DW), .RSP_DEPTH(RSPD), .INIT_VAL(INIT_V)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
    .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rd_data),
    .init_done(init_done)
  );

  // 16x8 synchronous dual-port RAM with registered read data, seeded on its first clock.
  logic [DW-1:0] ram [DEPTH];
  logic          ram_seeded = 1'b0;
  logic [DW-1:0] ram_q = '0;
  always @(posedge clk) begin
    if (!ram_seeded) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 8'hC0 + 8'(i);
      ram_seeded <= 1'b1;
    end else if (wr_enb) begin
      ram[wr_addr] <= wr_data;
    end
    if (rd_enb) ram_q <= ram[rd_addr];
  end
  assign rd_data = ram_q;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            vis;
  } rsp_t;

  logic [DW-1:0] exp_mem [DEPTH];
  rsp_t          q[$];
  int            cyc;
  logic          exp_wr, exp_rd;
  logic [AW-1:0] exp_wa, exp_ra;
  logic [DW-1:0] exp_wd;
  int            n_chk = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " cmd_ready"}, 32'(cmd_ready), 32'd0);
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " rsp_data"},  32'(rsp_data),  32'd0);
    check({tag, " rsp_addr"},  32'(rsp_addr),  32'd0);
    check({tag, " wr_enb"},    32'(wr_enb),    32'd0);
    check({tag, " wr_addr"},   32'(wr_addr),   32'd0);
    check({tag, " wr_data"},   32'(wr_data),   32'd0);
    check({tag, " rd_enb"},    32'(rd_enb),    32'd0);
    check({tag, " rd_addr"},   32'(rd_addr),   32'd0);
    check({tag, " init_done"}, 32'(init_done), 32'd0);
  endtask

  // One clock: called just after a falling edge; drives inputs, checks outputs
  // against the model, advances the model for the coming rising edge.
  // acc returns the handshake as seen on the DUT pins.
  task automatic cycle(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic rr, output logic acc);
    logic ex_rdy, ex_vld;
    cmd_valid = v; cmd_we = we; cmd_addr = a; cmd_wdata = d; rsp_ready = rr;
    #1;
    ex_rdy = (cyc >= RUN_CYC) && (we || q.size() < RSPD);
    check("cmd_ready", 32'(cmd_ready), 32'(ex_rdy));
    check("init_done", 32'(init_done), 32'(cyc >= RUN_CYC));
    if (INIT_EN && cyc >= 1 && cyc <= DEPTH) begin
      exp_wr = 1'b1; exp_wa = AW'(cyc - 1); exp_wd = INIT_V;
    end
    check("wr_enb", 32'(wr_enb), 32'(exp_wr));
    if (exp_wr) begin
      check("wr_addr", 32'(wr_addr), 32'(exp_wa));
      check("wr_data", 32'(wr_data), 32'(exp_wd));
    end
    check("rd_enb", 32'(rd_enb), 32'(exp_rd));
    if (exp_rd) check("rd_addr", 32'(rd_addr), 32'(exp_ra));
    ex_vld = (q.size() > 0) && (cyc >= q[0].vis);
    check("rsp_valid", 32'(rsp_valid), 32'(ex_vld));
    if (ex_vld) begin
      check("rsp_data", 32'(rsp_data), 32'(q[0].data));
      check("rsp_addr", 32'(rsp_addr), 32'(q[0].addr));
      if (rr) void'(q.pop_front());
    end
    acc = v && cmd_ready;
    exp_wr = 1'b0;
    exp_rd = 1'b0;
    if (v && ex_rdy) begin
      if (we) begin
        exp_mem[a] = d;
        exp_wr = 1'b1; exp_wa = a; exp_wd = d;
      end else begin
        // Accepted at the next rising edge; visible two edges after that.
        q.push_back('{a, exp_mem[a], cyc + 3});
        exp_rd = 1'b1; exp_ra = a;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rr);
    logic acc;
    repeat (n) cycle(1'b0, 1'b0, '0, '0, rr, acc);
  endtask

  task automatic release_reset();
    rst = 1'b1;
    cyc = 0;
    if (INIT_EN) for (int i = 0; i < DEPTH; i++) exp_mem[i] = INIT_V;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic          acc;
    int            cnt;
    logic          hv, hwe, pend, rr;
    logic [AW-1:0] ha;
    logic [DW-1:0] hd;

    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 8'hC0 + 8'(i);
    exp_wr = 1'b0; exp_rd = 1'b0; exp_wa = '0; exp_ra = '0; exp_wd = '0;
    cyc = 0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b1; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("por");
    release_reset();

    // Init sweep (if built in) and first RUN cycles.
    idle(RUN_CYC + 2, 1'b1);

    // Single read after init.
    cycle(1'b1, 1'b0, 4'h7, 8'h00, 1'b1, acc);
    idle(4, 1'b1);

    // Read-after-write on consecutive accepts.
    cycle(1'b1, 1'b1, 4'h3, 8'hA5, 1'b1, acc);
    cycle(1'b1, 1'b0, 4'h3, 8'h00, 1'b1, acc);
    idle(4, 1'b1);

    // Fill all locations, then stream back-to-back reads.
    for (int n = 0; n < DEPTH; n++) cycle(1'b1, 1'b1, AW'(n), 8'h10 + 8'(n), 1'b1, acc);
    for (int n = 0; n < DEPTH; n++) begin
      cycle(1'b1, 1'b0, AW'(n), 8'h00, 1'b1, acc);
      check("b2b_read_accept", 32'(acc), 32'd1);
    end
    idle(4, 1'b1);

    // Response back-pressure: credit stops reads at RSP_DEPTH, writes still go.
    cnt = 0;
    repeat (7) begin
      cycle(1'b1, 1'b0, 4'h5, 8'h00, 1'b0, acc);
      cnt += int'(acc);
    end
    check("stalled_read_accepts", 32'(cnt), 32'(RSPD));
    idle(1, 1'b0);
    cycle(1'b1, 1'b1, 4'h9, 8'h3C, 1'b0, acc);
    check("write_during_stall", 32'(acc), 32'd1);
    idle(6, 1'b1);
    cycle(1'b1, 1'b0, 4'h9, 8'h00, 1'b1, acc);
    check("read_resumes", 32'(acc), 32'd1);
    idle(4, 1'b1);

    // Randomized traffic; an unaccepted command is held unchanged.
    pend = 1'b0; hv = 1'b0; hwe = 1'b0; ha = '0; hd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        hv  = ($urandom_range(0, 3) != 0);
        hwe = 1'(($urandom_range(0, 1)));
        ha  = AW'($urandom_range(0, DEPTH - 1));
        hd  = DW'($urandom);
      end
      rr = ($urandom_range(0, 3) != 0);
      cycle(hv, hwe, ha, hd, rr, acc);
      pend = hv && !acc;
    end
    idle(6, 1'b1);
    check("queue_drained", 32'(q.size()), 32'd0);

    // Reset with two reads in flight and one response buffered.
    cycle(1'b1, 1'b0, 4'h2, 8'h00, 1'b0, acc);
    cycle(1'b1, 1'b0, 4'h6, 8'h00, 1'b0, acc);
    cycle(1'b1, 1'b0, 4'hB, 8'h00, 1'b0, acc);
    #1;
    check("pre_reset_rsp_valid", 32'(rsp_valid), 32'((q.size() > 0) && (cyc >= q[0].vis)));
    #1;
    rst = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b1; rsp_ready = 1'b0;
    #1;
    check_outputs_zero("midrst");
    q.delete();
    exp_wr = 1'b0; exp_rd = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    release_reset();
    idle(RUN_CYC + 4, 1'b1);
    cycle(1'b1, 1'b0, 4'hB, 8'h00, 1'b1, acc);
    cycle(1'b1, 1'b0, 4'h2, 8'h00, 1'b1, acc);
    idle(4, 1'b1);
    check("final_queue_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
